// File: rtl/truth_table_sweeper_pkg.sv
// Shared encodings for the truth-table sweeper: FSM states, vector/counter widths, status record.
// No timing of its own; no backpressure (types and constants only).
package truth_table_sweeper_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    // Result of a sweep; cleared together on start, so kept as one record.
    typedef struct packed {
        logic [IDX_W:0]   mismatch_cnt;
        logic [IDX_W-1:0] first_fail_idx;
        logic             fail_valid;
        logic             pass;
    } status_t;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle counter: terminal is high while the count equals SETTLE_CYCLES, wrapping to 0 there.
// Latency: terminal comes SETTLE_CYCLES cycles after clear drops; no backpressure (free-running while run=1).
module truth_table_sweeper_settle_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic terminal
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SETTLE_CYCLES);

    logic [CNT_W-1:0] cnt;

    assign terminal = (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= terminal ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 4-input function block through all 16 vectors and grades the captured truth table.
// Latency: 16*(SETTLE_CYCLES+1) cycles from start to done; no backpressure (start ignored unless idle).
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail_idx,
    output logic        fail_valid,
    output logic        pass
);

    logic [1:0]             state;
    logic [IDX_W-1:0]       idx;
    logic [NUM_VECTORS-1:0] exp_q;
    status_t                st;

    logic in_hold;
    logic settle_term;
    logic sample;
    logic miss;

    assign in_hold = (state == ST_HOLD);
    // abort wins over a sample landing on the same edge
    assign sample  = in_hold && !abort && settle_term;
    assign miss    = sample && (f_in != exp_q[idx]);

    truth_table_sweeper_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!in_hold || abort),
        .run      (in_hold),
        .terminal (settle_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            exp_q       <= '0;
            truth_table <= '0;
            st          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_HOLD;
                        idx         <= '0;
                        exp_q       <= expected;
                        truth_table <= '0;
                        st          <= '0;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else if (sample) begin
                        truth_table[idx] <= f_in;
                        if (miss) begin
                            st.mismatch_cnt <= st.mismatch_cnt + (IDX_W+1)'(1);
                            if (!st.fail_valid) begin
                                st.first_fail_idx <= idx;
                                st.fail_valid     <= 1'b1;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state   <= ST_DONE;
                            idx     <= '0;
                            // final sample is folded in here, so no extra cycle is needed in DONE
                            st.pass <= !miss && (st.mismatch_cnt == '0);
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign {w, x, y, z}   = idx;
    assign busy           = in_hold;
    assign done           = (state == ST_DONE);
    assign mismatch_cnt   = st.mismatch_cnt;
    assign first_fail_idx = st.first_fail_idx;
    assign fail_valid     = st.fail_valid;
    assign pass           = st.pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench: two sweepers (settle 2 and settle 0) driving an XOR-4 stand-in, checked against a timing/result model.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n;

    logic        start_s [2];
    logic        abort_s [2];
    logic [15:0] exp_s   [2];
    logic        f_s     [2];
    logic        w_s [2], x_s [2], y_s [2], z_s [2];
    logic        busy_s [2], done_s [2], fv_s [2], pass_s [2];
    logic [15:0] tt_s  [2];
    logic [4:0]  mc_s  [2];
    logic [3:0]  ffi_s [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state: sweep running, cycles since start edge, vectors captured, latched golden, pass
    bit          m_run  [2] = '{1'b0, 1'b0};
    int          m_t    [2] = '{0, 0};
    int          m_ns   [2] = '{0, 0};
    logic [15:0] m_exp  [2] = '{16'h0, 16'h0};
    bit          m_pass [2] = '{1'b0, 1'b0};

    logic [15:0] c_mask, c_diff;
    int          c_vec, c_p;
    logic        c_act;

    always #5 clk = ~clk;

    assign f_s[0] = w_s[0] ^ x_s[0] ^ y_s[0] ^ z_s[0];
    assign f_s[1] = w_s[1] ^ x_s[1] ^ y_s[1] ^ z_s[1];

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .expected(exp_s[0]), .f_in(f_s[0]),
        .w(w_s[0]), .x(x_s[0]), .y(y_s[0]), .z(z_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .truth_table(tt_s[0]),
        .mismatch_cnt(mc_s[0]), .first_fail_idx(ffi_s[0]),
        .fail_valid(fv_s[0]), .pass(pass_s[0])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .expected(exp_s[1]), .f_in(f_s[1]),
        .w(w_s[1]), .x(x_s[1]), .y(y_s[1]), .z(z_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .truth_table(tt_s[1]),
        .mismatch_cnt(mc_s[1]), .first_fail_idx(ffi_s[1]),
        .fail_valid(fv_s[1]), .pass(pass_s[1])
    );

    function automatic int period(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic logic [15:0] ref_table();
        logic [15:0] r;
        logic [3:0]  v;
        for (int i = 0; i < 16; i++) begin
            v    = 4'(i);
            r[i] = ^v;
        end
        return r;
    endfunction

    function automatic logic [15:0] upto(input int ns);
        logic [16:0] m;
        m = (17'h1 << ns) - 17'h1;
        return m[15:0];
    endfunction

    function automatic int lowest(input logic [15:0] d);
        int r;
        r = 0;
        for (int i = 15; i >= 0; i--) if (d[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, k, $time, got, want);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_run[k]  <= 1'b0;
                m_t[k]    <= 0;
                m_ns[k]   <= 0;
                m_exp[k]  <= 16'h0;
                m_pass[k] <= 1'b0;
            end else if (m_run[k]) begin
                if (m_t[k] == 16 * period(k) || abort_s[k]) begin
                    m_run[k] <= 1'b0;
                end else begin
                    m_t[k]  <= m_t[k] + 1;
                    m_ns[k] <= (m_t[k] + 1) / period(k);
                    if (m_t[k] + 1 == 16 * period(k))
                        m_pass[k] <= ((ref_table() ^ m_exp[k]) == 16'h0);
                end
            end else if (start_s[k]) begin
                m_run[k]  <= 1'b1;
                m_t[k]    <= 0;
                m_ns[k]   <= 0;
                m_exp[k]  <= exp_s[k];
                m_pass[k] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                c_p    = period(k);
                c_act  = m_run[k] && (m_t[k] < 16 * c_p);
                c_vec  = c_act ? m_t[k] / c_p : 0;
                c_mask = upto(m_ns[k]);
                c_diff = (ref_table() ^ m_exp[k]) & c_mask;
                chk("busy", k, busy_s[k], c_act);
                chk("done", k, done_s[k], m_run[k] && (m_t[k] == 16 * c_p));
                chk("vector", k, {w_s[k], x_s[k], y_s[k], z_s[k]}, c_vec);
                chk("table", k, tt_s[k], ref_table() & c_mask);
                chk("mismatch_cnt", k, mc_s[k], $countones(c_diff));
                chk("fail_valid", k, fv_s[k], c_diff != 16'h0);
                if (c_diff != 16'h0) chk("first_fail_idx", k, ffi_s[k], lowest(c_diff));
                chk("pass", k, pass_s[k], m_pass[k]);
            end
        end
    end

    task automatic pulse_start(input int k, input logic [15:0] e);
        @(negedge clk);
        exp_s[k]   = e;
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    task automatic run_to_done(input int k, output int n);
        n = 0;
        while (done_s[k] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", k, done_s[k], 1'b1);
    endtask

    task automatic count_done(input int k, input int cycles, output int nd);
        nd = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done_s[k] === 1'b1) nd++;
        end
    endtask

    task automatic sweep(input int k, input logic [15:0] e, input int want_n, input logic [15:0] want_tt,
                         input int want_mc, input int want_ffi, input logic want_pass);
        int n;
        pulse_start(k, e);
        run_to_done(k, n);
        chk("lit_latency", k, n, want_n);
        chk("lit_table", k, tt_s[k], want_tt);
        chk("lit_mcnt", k, mc_s[k], want_mc);
        chk("lit_fail_valid", k, fv_s[k], want_mc != 0);
        if (want_mc != 0) chk("lit_ffi", k, ffi_s[k], want_ffi);
        chk("lit_pass", k, pass_s[k], want_pass);
    endtask

    initial begin
        int n, nd;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            abort_s[k] = 1'b0;
            exp_s[k]   = 16'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, busy_s[0], 1'b0);
        chk("rst_done", 0, done_s[0], 1'b0);
        chk("rst_vector", 0, {w_s[0], x_s[0], y_s[0], z_s[0]}, 4'h0);
        chk("rst_table", 0, tt_s[0], 16'h0);
        chk("rst_mcnt", 0, mc_s[0], 5'd0);
        chk("rst_pass", 0, pass_s[0], 1'b0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        sweep(0, 16'h6996, 48, 16'h6996, 0, 0, 1'b1);
        sweep(0, 16'h6997, 48, 16'h6996, 1, 0, 1'b0);
        sweep(0, 16'h9669, 48, 16'h6996, 16, 0, 1'b0);
        sweep(0, 16'hE996, 48, 16'h6996, 1, 15, 1'b0);

        // start re-pulsed mid-sweep with a different golden, then again during DONE
        pulse_start(0, 16'h6996);
        repeat (9) @(negedge clk);
        start_s[0] = 1'b1;
        exp_s[0]   = 16'h0000;
        @(negedge clk);
        start_s[0] = 1'b0;
        run_to_done(0, n);
        chk("restart_latency", 0, n, 38);
        chk("restart_mcnt", 0, mc_s[0], 5'd0);
        chk("restart_pass", 0, pass_s[0], 1'b1);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        count_done(0, 60, nd);
        chk("extra_done", 0, nd, 0);
        chk("idle_busy", 0, busy_s[0], 1'b0);

        // abort on the edge after vector 2 is sampled
        pulse_start(0, 16'h6996);
        repeat (9) @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk("abort_busy", 0, busy_s[0], 1'b0);
        chk("abort_vector", 0, {w_s[0], x_s[0], y_s[0], z_s[0]}, 4'h0);
        chk("abort_table", 0, tt_s[0], 16'h0006);
        chk("abort_pass", 0, pass_s[0], 1'b0);
        count_done(0, 60, nd);
        chk("abort_done", 0, nd, 0);

        // asynchronous reset in the middle of a failing sweep
        pulse_start(0, 16'h9669);
        repeat (20) @(negedge clk);
        chk("pre_rst_mcnt", 0, mc_s[0], 5'd6);
        chk("pre_rst_table", 0, tt_s[0], 16'h0016);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 0, busy_s[0], 1'b0);
        chk("arst_vector", 0, {w_s[0], x_s[0], y_s[0], z_s[0]}, 4'h0);
        chk("arst_table", 0, tt_s[0], 16'h0);
        chk("arst_mcnt", 0, mc_s[0], 5'd0);
        chk("arst_fail_valid", 0, fv_s[0], 1'b0);
        chk("arst_ffi", 0, ffi_s[0], 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep(1, 16'h6996, 16, 16'h6996, 0, 0, 1'b1);
        sweep(1, 16'h0000, 16, 16'h6996, 8, 1, 1'b0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
